// File: rtl/seqdet_prog.sv
// Programmable serial pattern detector with per-bit masking, overlap control
// and a saturating match counter.
module seqdet_prog #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic [PAT_W-1:0] pat,
    input  logic [PAT_W-1:0] pat_mask,
    input  logic             load,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask_q;
    logic [FW-1:0]    fill;

    logic [PAT_W-1:0] hist_sh;
    logic [FW-1:0]    fill_inc;
    logic             hit;

    // NOTE: every signal gets a value on every path of always_comb, so no latch is inferred.
    always_comb begin
        hist_sh  = {hist[PAT_W-2:0], x};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_ONE;
        hit      = x_valid && !load && (fill_inc == FILL_FULL) &&
                   (((hist_sh ^ pat_q) & mask_q) == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state     <= IDLE;
            hist      <= '0;
            fill      <= '0;
            pat_q     <= '0;
            mask_q    <= '1;
            y         <= 1'b0;
            match_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            y <= hit;

            // Clear wins over a same-cycle match; y above still pulses.
            if (clr_cnt) begin
                match_cnt <= '0;
            end else if (hit && match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + CNT_ONE;
            end

            if (load) begin
                pat_q  <= pat;
                mask_q <= pat_mask;
                hist   <= '0;
                fill   <= '0;
                state  <= IDLE;
                armed  <= 1'b0;
            end else if (x_valid) begin
                hist <= hist_sh;
                if (hit && !overlap) begin
                    fill  <= '0;
                    state <= IDLE;
                    armed <= 1'b0;
                end else begin
                    fill  <= fill_inc;
                    armed <= (fill_inc == FILL_FULL);
                    state <= (fill_inc == FILL_FULL) ? ARMED : FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_seqdet_prog.sv
// Scoreboard bench for seqdet_prog: a PAT_W=5/CNT_W=8 instance and a
// PAT_W=2/CNT_W=2 instance checked against a behavioural reference model.
module tb_seqdet_prog;

    logic       Clk;
    logic       rst_a, x_a, xv_a, load_a, ov_a, clr_a;
    logic [4:0] pat_a, mask_a;
    logic       y_a, armed_a;
    logic [7:0] cnt_a;

    logic       rst_b, x_b, xv_b, load_b, ov_b, clr_b;
    logic [1:0] pat_b, mask_b;
    logic       y_b, armed_b;
    logic [1:0] cnt_b;

    seqdet_prog #(.PAT_W(5), .CNT_W(8)) dut_a (
        .Clk(Clk), .rst(rst_a), .x(x_a), .x_valid(xv_a), .pat(pat_a), .pat_mask(mask_a),
        .load(load_a), .overlap(ov_a), .clr_cnt(clr_a), .y(y_a), .match_cnt(cnt_a), .armed(armed_a)
    );

    seqdet_prog #(.PAT_W(2), .CNT_W(2)) dut_b (
        .Clk(Clk), .rst(rst_b), .x(x_b), .x_valid(xv_b), .pat(pat_b), .pat_mask(mask_b),
        .load(load_b), .overlap(ov_b), .clr_cnt(clr_b), .y(y_b), .match_cnt(cnt_b), .armed(armed_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int    id;
        int    y;
        int    cnt;
        int    armed;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int pw[2]   = '{5, 2};
    int cmax[2] = '{255, 3};
    int m_pat[2], m_mask[2], m_hist[2], m_fill[2], m_cnt[2], m_y[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model(input int id, input bit r, input bit ld, input bit xv, input bit xb,
                         input bit ov, input bit cl, input int p, input int mk);
        int  full;
        int  nh;
        bit  hit;
        full = (1 << pw[id]) - 1;
        hit  = 1'b0;
        if (r) begin
            m_pat[id]  = 0;
            m_mask[id] = full;
            m_hist[id] = 0;
            m_fill[id] = 0;
            m_cnt[id]  = 0;
            m_y[id]    = 0;
            return;
        end
        if (ld) begin
            m_pat[id]  = p & full;
            m_mask[id] = mk & full;
            m_hist[id] = 0;
            m_fill[id] = 0;
        end else if (xv) begin
            nh         = ((m_hist[id] << 1) | int'(xb)) & full;
            m_hist[id] = nh;
            if (m_fill[id] < pw[id]) m_fill[id]++;
            if (m_fill[id] == pw[id] && ((nh ^ m_pat[id]) & m_mask[id]) == 0) begin
                hit = 1'b1;
                if (!ov) m_fill[id] = 0;
            end
        end
        m_y[id] = int'(hit);
        if (cl) m_cnt[id] = 0;
        else if (hit && m_cnt[id] < cmax[id]) m_cnt[id]++;
    endtask

    task automatic step(input int id, input bit r, input bit ld, input bit xv, input bit xb,
                        input bit ov, input bit cl, input string tag);
        exp_t e;
        @(negedge Clk);
        rst_a  = (id == 0) && r;  load_a = (id == 0) && ld; xv_a = (id == 0) && xv;
        x_a    = xb;              ov_a   = ov;              clr_a = (id == 0) && cl;
        rst_b  = (id == 1) && r;  load_b = (id == 1) && ld; xv_b = (id == 1) && xv;
        x_b    = xb;              ov_b   = ov;              clr_b = (id == 1) && cl;
        model(0, rst_a, load_a, xv_a, xb, ov, clr_a, int'(pat_a), int'(mask_a));
        model(1, rst_b, load_b, xv_b, xb, ov, clr_b, int'(pat_b), int'(mask_b));
        e.id    = id;
        e.y     = m_y[id];
        e.cnt   = m_cnt[id];
        e.armed = int'(m_fill[id] == pw[id]);
        e.tag   = tag;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        if (e.id == 0) begin
            check({e.tag, ".y"},     32'(y_a),     32'(e.y));
            check({e.tag, ".cnt"},   32'(cnt_a),   32'(e.cnt));
            check({e.tag, ".armed"}, 32'(armed_a), 32'(e.armed));
        end else begin
            check({e.tag, ".y"},     32'(y_b),     32'(e.y));
            check({e.tag, ".cnt"},   32'(cnt_b),   32'(e.cnt));
            check({e.tag, ".armed"}, 32'(armed_b), 32'(e.armed));
        end
    endtask

    task automatic load_a_pat(input logic [4:0] p, input logic [4:0] m, input string tag);
        pat_a  = p;
        mask_a = m;
        step(0, 0, 1, 0, 0, 0, 0, tag);
    endtask

    initial begin
        logic [7:0] s8;
        logic [4:0] s5;
        logic [4:0] exp_y;

        {rst_a, x_a, xv_a, load_a, ov_a, clr_a} = '0;
        {rst_b, x_b, xv_b, load_b, ov_b, clr_b} = '0;
        pat_a = '0; mask_a = '0; pat_b = '0; mask_b = '0;

        step(0, 1, 0, 0, 0, 0, 0, "rst_a");
        step(1, 1, 0, 0, 0, 0, 0, "rst_b");

        // Reset pattern is all zeros with a full mask: five zeros must match.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1, 0, "rst_pat");
        check("rst_pat_hit", 32'(cnt_a), 32'd1);

        // Overlapping detection of 10010 on 10010010.
        load_a_pat(5'b10010, 5'b11111, "ld_ov");
        s8 = 8'b10010010;
        for (int i = 7; i >= 0; i--) step(0, 0, 0, 1, s8[i], 1, 0, "ov1");
        check("ov1_total", 32'(cnt_a), 32'd3);

        // Non-overlapping: only the first match, armed drops afterwards.
        step(0, 0, 0, 0, 0, 0, 1, "clr");
        load_a_pat(5'b10010, 5'b11111, "ld_nov");
        for (int i = 7; i >= 0; i--) step(0, 0, 0, 1, s8[i], 0, 0, "ov0");
        check("ov0_total", 32'(cnt_a), 32'd1);
        check("ov0_armed", 32'(armed_a), 32'd0);

        // Masked bit 2 is a don't-care.
        load_a_pat(5'b10010, 5'b11011, "ld_mask");
        s5 = 5'b10110;
        exp_y = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 1, s5[i], 1, 0, "mask");
            check("mask_y", 32'(y_a), 32'(exp_y[i]));
        end

        // Gapped valid: idle cycles carry x=1 which must be ignored.
        load_a_pat(5'b10010, 5'b11111, "ld_gap");
        s5 = 5'b10010;
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 1, s5[i], 1, 0, "gap_v");
            step(0, 0, 0, 0, 1, 1, 0, "gap_i");
        end

        // Pattern input changes without load have no effect.
        pat_a = 5'b01101; mask_a = 5'b00000;
        for (int i = 4; i >= 0; i--) step(0, 0, 0, 1, s5[i], 0, 0, "noload");

        // Reset after four bits discards history; then load after four bits.
        for (int i = 4; i >= 1; i--) step(0, 0, 0, 1, s5[i], 1, 0, "pre_rst");
        step(0, 1, 1, 1, 0, 1, 1, "rst_prio");
        step(0, 0, 0, 1, 0, 1, 0, "post_rst");
        check("post_rst_fill_y", 32'({y_a, armed_a}), 32'd0);
        load_a_pat(5'b10010, 5'b11111, "ld_re");
        for (int i = 4; i >= 1; i--) step(0, 0, 0, 1, s5[i], 1, 0, "pre_ld");
        pat_a = 5'b10010; mask_a = 5'b11111;
        step(0, 0, 1, 1, 0, 1, 0, "ld_discard");
        step(0, 0, 0, 1, 0, 1, 0, "post_ld");
        for (int i = 4; i >= 0; i--) step(0, 0, 0, 1, s5[i], 1, 0, "restart");

        // All-zero mask matches every window once armed.
        load_a_pat(5'b00000, 5'b00000, "ld_zero");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i[0], 1, 0, "zmask");

        // Saturating 2-bit counter with pattern 11.
        pat_b = 2'b11; mask_b = 2'b11;
        step(1, 0, 1, 0, 0, 1, 0, "ld_b");
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1, 1, 0, "sat");
        check("sat_total", 32'(cnt_b), 32'd3);
        step(1, 0, 0, 1, 1, 1, 1, "clr_hit");
        check("clr_hit_y", 32'(y_b), 32'd1);
        check("clr_hit_cnt", 32'(cnt_b), 32'd0);

        // Random traffic with occasional reloads, overlap flips and clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pat_a  = 5'($urandom());
                mask_a = 5'($urandom()) | 5'($urandom());
                step(0, 0, 1, $urandom_range(0, 1) == 1, 1'($urandom()), 1'($urandom()), 0, "rnd_ld");
            end else begin
                step(0, $urandom_range(0, 99) == 0, 0, $urandom_range(0, 3) != 0,
                     1'($urandom()), 1'($urandom()), $urandom_range(0, 49) == 0, "rnd");
            end
        end
        for (int i = 0; i < 100; i++) begin
            pat_b = 2'($urandom()); mask_b = 2'($urandom());
            step(1, 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom()), 1'($urandom()), $urandom_range(0, 29) == 0, "rnd_b");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seqdet_prog.md
SEQDET_PROG -- requirements
Module: seqdet_prog

Interface
REQ-001 SHALL provide parameter PAT_W, default 5, pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter CNT_W, default 8, match counter width (legal 1..16).
REQ-003 SHALL provide Clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL provide rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide x  input  1  serial sequence bit.
REQ-006 SHALL provide x_valid  input  1  x is sampled only when high.
REQ-007 SHALL provide pat  input  PAT_W  target pattern; pat[PAT_W-1] matches the oldest bit, pat[0] the newest.
REQ-008 SHALL provide pat_mask  input  PAT_W  per-bit compare enable; 0 = don't-care.
REQ-009 SHALL provide load  input  1  one-cycle strobe that captures pat/pat_mask and restarts detection.
REQ-010 SHALL provide overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-011 SHALL provide clr_cnt  input  1  synchronous clear of match counter.
REQ-012 SHALL provide y  output  1  registered one-cycle match pulse.
REQ-013 SHALL provide match_cnt  output  CNT_W  saturating count of matches.
REQ-014 SHALL provide armed  output  1  high when a full window of PAT_W bits is held.

Function
REQ-015 SHALL hold a PAT_W-bit history register; each x_valid cycle shifts left, x enters bit 0.
REQ-016 SHALL hold fill counter (0..PAT_W); increments per accepted bit, saturates at PAT_W; armed = (fill == PAT_W).
REQ-017 SHALL use FSM states IDLE (fill==0), FILL (0<fill<PAT_W), ARMED (fill==PAT_W); IDLE->FILL on first accepted bit, FILL->ARMED on PAT_W-th bit, ARMED stays until restart.
REQ-018 SHALL declare a match in the cycle where an accepted bit makes the shifted history equal to the captured pattern on all mask-1 positions with the post-shift fill == PAT_W.
REQ-019 SHALL assert y for exactly one cycle, the cycle after the completing bit is sampled (latency 1); y low otherwise.
REQ-020 SHALL, with overlap=1, keep history and fill after a match, so the next match may share bits.
REQ-021 SHALL, with overlap=0, reset fill to 0 (state IDLE) after a match; the next match requires PAT_W fresh bits.
REQ-022 SHALL ignore x when x_valid=0: history, fill, and state hold; y=0 next cycle.
REQ-023 SHALL, on load=1, capture pat and pat_mask, clear history and fill (IDLE), and discard any same-cycle x_valid bit; load does not change match_cnt.
REQ-024 SHALL use the captured pattern/mask only; pat and pat_mask changes without load have no effect.
REQ-025 SHALL treat all-zero pat_mask as matching every window once armed.
REQ-026 SHALL increment match_cnt by 1 per match, saturate at 2^CNT_W-1, and never wrap.
REQ-027 SHALL give clr_cnt priority over a same-cycle increment (count becomes 0); y still pulses for that match.
REQ-028 SHALL sample overlap on the completing-bit cycle.

Reset
REQ-029 SHALL, on rst=1 at posedge, set y=0, match_cnt=0, armed=0, history=0, fill=0, state IDLE; captured pattern = all zeros, mask = all ones.
REQ-030 SHALL give rst priority over load, clr_cnt and x_valid; reset mid-sequence discards partial history.

Verification
REQ-031 PAT_W=5, load pat=10010 mask=11111, overlap=1, stream 1001001 0 -> y pulses one cycle after 5th and 8th bits; match_cnt=2.
REQ-032 Same pattern, overlap=0, stream 10010010 -> single y after 5th bit; match_cnt=1; armed drops after the match.
REQ-033 pat=10010 mask=11011, stream 10110 -> y pulses one cycle after 5th bit (bit 2 don't-care).
REQ-034 x_valid toggled 1,0,1,0... with bits 1,0,0,1,0 on valid cycles -> exactly one y, one cycle after the last valid bit; no y on gaps.
REQ-035 CNT_W=2, overlap=1, pattern 11 mask 11, stream of 6 ones -> match_cnt 1,2,3,3,3; clr_cnt together with a match -> match_cnt=0, y=1.
REQ-036 rst or load asserted after 4 bits of 10010 then final 0 applied -> no y; armed=0; fill restarts from 0.
